// File: rtl/data_ram_arbiter_if.sv
// Data RAM arbiter bus bundle: two requester ports plus the shared RAM port.
// The slave modport is the arbiter's view; the master modport is the view of
// the surrounding system (both requesters and the RAM read-data return).
interface data_ram_arbiter_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 8
);
  // Port 0: CPU core
  logic              req0;
  logic              we0;
  logic [ADDR_W-1:0] addr0;
  logic [DATA_W-1:0] wdata0;
  logic              gnt0;
  logic              rvalid0;
  logic [DATA_W-1:0] rdata0;

  // Port 1: host loader / dump engine
  logic              req1;
  logic              we1;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata1;
  logic              gnt1;
  logic              rvalid1;
  logic [DATA_W-1:0] rdata1;

  // Shared data RAM port
  logic              data_ram_we;
  logic [ADDR_W-1:0] addr_data_ram;
  logic [DATA_W-1:0] din_data_ram;
  logic [DATA_W-1:0] dout_data_ram;

  modport slave (
    input  req0, we0, addr0, wdata0,
    input  req1, we1, addr1, wdata1,
    input  dout_data_ram,
    output gnt0, rvalid0, rdata0,
    output gnt1, rvalid1, rdata1,
    output data_ram_we, addr_data_ram, din_data_ram
  );

  modport master (
    output req0, we0, addr0, wdata0,
    output req1, we1, addr1, wdata1,
    output dout_data_ram,
    input  gnt0, rvalid0, rdata0,
    input  gnt1, rvalid1, rdata1,
    input  data_ram_we, addr_data_ram, din_data_ram
  );
endinterface

// File: rtl/data_ram_arbiter.sv
// Two-port arbiter for the single synchronous data RAM port.
// Port 0 is the CPU core, port 1 the host loader/dump engine. Ownership is a
// registered three-state FSM; an owner may be preempted once it has completed
// MAX_BURST beats while the other port waits. Read data is routed back to the
// port that issued the read, one cycle after acceptance.
//
// Build option ARB_ROUND_ROBIN_EN:
//   defined   - IDLE ties go to the port that did not own the RAM last, and
//               the burst limit preempts either port.
//   undefined - fixed priority: port 0 wins IDLE ties and is never preempted.
module data_ram_arbiter #(
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned MAX_BURST = 16  // legal 1..255
) (
  input logic               clk_in,
  input logic               reset,  // asynchronous, active low
  data_ram_arbiter_if.slave bus
);

  localparam logic [7:0] MaxBurst = 8'(MAX_BURST);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StOwn0 = 2'd1,
    StOwn1 = 2'd2
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] beat_cnt_q, beat_cnt_d;
  logic [7:0] beat_cnt_inc;
  logic       gnt0, gnt1;
  logic       own_req;
  logic       own_we;
  logic       accept;
  logic       burst_done;
  logic       rd_pend_q, rd_pend_d;
  logic       rd_id_q, rd_id_d;

`ifdef ARB_ROUND_ROBIN_EN
  // 0 = port 0 owned the RAM most recently, 1 = port 1.
  logic       last_owner_q, last_owner_d;
`endif

  // Grants are decodes of the registered state, so they carry no input logic.
  assign gnt0 = (state_q == StOwn0);
  assign gnt1 = (state_q == StOwn1);

  // Current owner's handshake and the beat-acceptance strobe.
  always_comb begin
    own_req = 1'b0;
    own_we  = 1'b0;
    if (gnt0) begin
      own_req = bus.req0;
      own_we  = bus.we0;
    end else if (gnt1) begin
      own_req = bus.req1;
      own_we  = bus.we1;
    end
  end

  assign accept = own_req;

  // Count including the beat accepted this cycle, so the owner is switched on
  // the same edge that completes its MAX_BURST-th beat.
  always_comb begin
    beat_cnt_inc = beat_cnt_q;
    if (accept && (beat_cnt_q != MaxBurst)) begin
      beat_cnt_inc = beat_cnt_q + 8'd1;
    end
  end

  assign burst_done = (beat_cnt_inc == MaxBurst);

  // Next-state decision for the grant FSM.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (bus.req0 && bus.req1) begin
`ifdef ARB_ROUND_ROBIN_EN
          state_d = last_owner_q ? StOwn0 : StOwn1;
`else
          state_d = StOwn0;
`endif
        end else if (bus.req0) begin
          state_d = StOwn0;
        end else if (bus.req1) begin
          state_d = StOwn1;
        end
      end
      StOwn0: begin
        if (!bus.req0) begin
          state_d = bus.req1 ? StOwn1 : StIdle;
        end
`ifdef ARB_ROUND_ROBIN_EN
        else if (burst_done && bus.req1) begin
          state_d = StOwn1;
        end
`endif
      end
      StOwn1: begin
        if (!bus.req1) begin
          state_d = bus.req0 ? StOwn0 : StIdle;
        end else if (burst_done && bus.req0) begin
          state_d = StOwn0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Beat counter restarts whenever the grant changes hands (including to idle).
  always_comb begin
    beat_cnt_d = beat_cnt_inc;
    if (state_d != state_q) begin
      beat_cnt_d = 8'd0;
    end
  end

`ifdef ARB_ROUND_ROBIN_EN
  // Remember the most recent owner for IDLE tie-breaking.
  always_comb begin
    last_owner_d = last_owner_q;
    if ((state_d == StOwn0) && (state_q != StOwn0)) begin
      last_owner_d = 1'b0;
    end else if ((state_d == StOwn1) && (state_q != StOwn1)) begin
      last_owner_d = 1'b1;
    end
  end
`endif

  // An accepted read flags a return for the issuing port on the next cycle.
  always_comb begin
    rd_pend_d = accept && !own_we;
    rd_id_d   = gnt1;
  end

  // Grant state, burst counter and read-return flag registers.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      beat_cnt_q <= 8'd0;
      rd_pend_q  <= 1'b0;
      rd_id_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      rd_pend_q  <= rd_pend_d;
      rd_id_q    <= rd_id_d;
    end
  end

`ifdef ARB_ROUND_ROBIN_EN
  // Last-owner pointer; reset to port 1 so the first tie goes to port 0.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      last_owner_q <= 1'b1;
    end else begin
      last_owner_q <= last_owner_d;
    end
  end
`endif

  // RAM port mux: only an owner with its request high drives the RAM.
  always_comb begin
    bus.data_ram_we   = 1'b0;
    bus.addr_data_ram = '0;
    bus.din_data_ram  = '0;
    if (gnt0 && bus.req0) begin
      bus.data_ram_we   = bus.we0;
      bus.addr_data_ram = bus.addr0;
      bus.din_data_ram  = bus.wdata0;
    end else if (gnt1 && bus.req1) begin
      bus.data_ram_we   = bus.we1;
      bus.addr_data_ram = bus.addr1;
      bus.din_data_ram  = bus.wdata1;
    end
  end

  // Grant and read-return outputs; RAM read data fans out to both ports.
  always_comb begin
    bus.gnt0    = gnt0;
    bus.gnt1    = gnt1;
    bus.rvalid0 = rd_pend_q && !rd_id_q;
    bus.rvalid1 = rd_pend_q && rd_id_q;
    bus.rdata0  = bus.dout_data_ram;
    bus.rdata1  = bus.dout_data_ram;
  end

endmodule
